ipsxe_fft_sreg_delay_ctrl: RTL

// - Sequencer for one FFT dynamic-latency distributed shift register (delay line).
// - Owns the line's depth configuration, gates the shift enable from an input valid stream,

---
 rtl/ipsxe_fft_sreg_delay_ctrl_if.sv | 30 +++
 rtl/ipsxe_fft_sreg_delay_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ipsxe_fft_sreg_delay_ctrl_if.sv
// Sample-stream, configuration and delay-line control bundle for the FFT
// shift-register delay controller. The master side is the stage driving
// samples and depth requests. The slave side is the controller.
interface ipsxe_fft_sreg_delay_ctrl_if #(
  parameter int unsigned CNT_WIDTH  = 5,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  cfg_valid;
  logic [CNT_WIDTH-1:0]  cfg_depth;
  logic                  cfg_ready;
  logic                  cfg_err;
  logic                  flush;
  logic                  s_valid;
  logic                  s_ready;
  logic                  sreg_clken;
  logic [ADDR_WIDTH-1:0] sreg_addr;
  logic                  m_valid;
  logic [CNT_WIDTH-1:0]  fill_cnt;
  logic                  busy;

  modport master (
    output cfg_valid, cfg_depth, flush, s_valid,
    input  cfg_ready, cfg_err, s_ready, sreg_clken, sreg_addr, m_valid, fill_cnt, busy
  );

  modport slave (
    input  cfg_valid, cfg_depth, flush, s_valid,
    output cfg_ready, cfg_err, s_ready, sreg_clken, sreg_addr, m_valid, fill_cnt, busy
  );
endinterface

// File: rtl/ipsxe_fft_sreg_delay_ctrl.sv
// Sequencer for one dynamic-latency FFT delay line. It holds the programmed
// depth, gates the shift enable from the input stream, and counts the fill
// level. It flags delayed samples as valid once the line is primed.
module ipsxe_fft_sreg_delay_ctrl #(
  parameter int unsigned MAX_DEPTH  = 14,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ipsxe_fft_sreg_delay_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECFG = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_D = CNT_WIDTH'(MAX_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  depth_q, depth_d;
  logic [CNT_WIDTH-1:0]  fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  m_valid_q, m_valid_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  s_ready;
  logic                  cfg_ready;
  logic                  acc;
  logic                  cfg_hs;
  logic                  cfg_legal;
  logic [CNT_WIDTH-1:0]  fill_inc;

  // Handshake readiness is a pure state decode, so it has no input-to-output path.
  always_comb begin
    s_ready   = 1'b0;
    cfg_ready = 1'b0;
    unique case (state_q)
      ST_IDLE:  cfg_ready = 1'b1;
      ST_RECFG: ;
      ST_FILL,
      ST_RUN: begin
        s_ready   = 1'b1;
        cfg_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign acc       = bus.s_valid & s_ready;
  assign cfg_hs    = bus.cfg_valid & cfg_ready;
  assign cfg_legal = (bus.cfg_depth != '0) && (bus.cfg_depth <= MAX_D);
  assign fill_inc  = fill_q + ONE;

  // Next-state logic. Priority order: legal config, then flush, then fill update.
  // A coincident accept still shifts the line. Its output validity uses the old
  // fill level and depth. The refill after config or flush then discards it.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    fill_d    = fill_q;
    addr_d    = addr_q;
    m_valid_d = acc & (fill_q >= depth_q);
    cfg_err_d = cfg_hs & ~cfg_legal;
    if (cfg_hs && cfg_legal) begin
      state_d = ST_RECFG;
      depth_d = bus.cfg_depth;
      addr_d  = ADDR_WIDTH'(bus.cfg_depth - ONE);
      fill_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:  ;
        ST_RECFG: state_d = ST_FILL;
        ST_FILL,
        ST_RUN: begin
          if (bus.flush) begin
            fill_d  = '0;
            state_d = ST_FILL;
          end else if (acc && (state_q == ST_FILL)) begin
            fill_d = fill_inc;
            if (fill_inc == depth_q) begin
              state_d = ST_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs. Reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      depth_q   <= '0;
      fill_q    <= '0;
      addr_q    <= '0;
      m_valid_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      fill_q    <= fill_d;
      addr_q    <= addr_d;
      m_valid_q <= m_valid_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.cfg_ready  = cfg_ready;
  assign bus.sreg_clken = acc;
  assign bus.sreg_addr  = addr_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.fill_cnt   = fill_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
